// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Purpose:
//   Control FSM for an instruction fetch unit. It issues increment-PC strobes
//   (en_pc) and load-PC strobes (en_new_pc / new_pc). It keeps a shadow copy of
//   the fetch unit PC, a registered instruction-valid flag, a one-cycle flush
//   pulse after every PC load, and a saturating count of en_pc strobes.
//
//   States: IDLE=0, RUN=1, STALL=2, REDIRECT=3, HALTED=4. Encodings 5-7
//   return to IDLE on the next clock. Outside IDLE the inputs are prioritised
//   halt_req > redirect > stall.
//
// Configuration:
//   FETCH_SEQ_STEP_EN - when defined, adds the 'step' input. In RUN, en_pc is
//                       then issued only in cycles where step=1. Otherwise the
//                       FSM holds RUN without fetching.
//
// Ports:
//   clk          in   1   clock
//   reset        in   1   asynchronous, active-high reset
//   start        in   1   leave IDLE/HALTED and begin fetching
//   halt_req     in   1   stop fetching (level)
//   stall        in   1   hold PC, no fetch (level)
//   redirect     in   1   load redirect_pc into the fetch PC (single cycle)
//   redirect_pc  in  12   branch/jump target
//   step         in   1   single-step enable (FETCH_SEQ_STEP_EN only)
//   en_pc        out  1   increment-PC strobe
//   en_new_pc    out  1   load-PC strobe
//   new_pc       out 12   PC value to load (0 when en_new_pc=0)
//   fetch_pc     out 12   shadow copy of the fetch unit PC
//   instr_valid  out  1   instruction register holds a correct instruction
//   flush        out  1   one-cycle pulse after a PC load
//   state        out  3   FSM state encoding
//   fetch_count  out 16   saturating count of en_pc strobes
// -----------------------------------------------------------------------------
module fetch_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        halt_req,
    input  logic        stall,
    input  logic        redirect,
    input  logic [11:0] redirect_pc,
`ifdef FETCH_SEQ_STEP_EN
    input  logic        step,
`endif
    output logic        en_pc,
    output logic        en_new_pc,
    output logic [11:0] new_pc,
    output logic [11:0] fetch_pc,
    output logic        instr_valid,
    output logic        flush,
    output logic [2:0]  state,
    output logic [15:0] fetch_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUN      = 3'd1,
        S_STALL    = 3'd2,
        S_REDIRECT = 3'd3,
        S_HALTED   = 3'd4
    } state_e;

    state_e      state_q;
    state_e      state_d;
    logic        en_pc_s;
    logic        en_new_pc_s;
    logic        step_ok_s;
    logic [11:0] fetch_pc_q;
    logic [11:0] fetch_pc_d;
    logic [15:0] fetch_count_q;
    logic [15:0] fetch_count_d;
    logic        instr_valid_q;
    logic        flush_q;

`ifdef FETCH_SEQ_STEP_EN
    assign step_ok_s = step;
`else
    assign step_ok_s = 1'b1;
`endif

    // State register; reset abandons any pending stall or redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe decode. The strobes are combinational because the
    // fetch unit acts on them in the same cycle the inputs arrive.
    always_comb begin
        state_d     = S_IDLE;
        en_pc_s     = 1'b0;
        en_new_pc_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (halt_req) begin
                    state_d = S_HALTED;
                end else if (redirect) begin
                    en_new_pc_s = 1'b1;
                    state_d     = S_REDIRECT;
                end else if (stall) begin
                    state_d = S_STALL;
                end else begin
                    // In single-step builds a RUN cycle without step is idle.
                    en_pc_s = step_ok_s;
                    state_d = S_RUN;
                end
            end
            S_STALL: begin
                if (halt_req) begin
                    state_d = S_HALTED;
                end else if (redirect) begin
                    en_new_pc_s = 1'b1;
                    state_d     = S_REDIRECT;
                end else if (stall) begin
                    state_d = S_STALL;
                end else begin
                    // The exit cycle does not fetch; RUN fetches from the next cycle.
                    state_d = S_RUN;
                end
            end
            S_REDIRECT: begin
                // One-cycle bubble while the loaded PC propagates.
                if (halt_req) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_HALTED: begin
                if (start && !halt_req) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_HALTED;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next values: the shadow PC wraps naturally at 12 bits, and the
    // count sticks at all-ones.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        fetch_count_d = fetch_count_q;
        if (en_new_pc_s) begin
            fetch_pc_d = redirect_pc;
        end else if (en_pc_s) begin
            fetch_pc_d = fetch_pc_q + 12'd1;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
        if (en_pc_s && (fetch_count_q != 16'hFFFF)) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end else begin
            fetch_count_d = fetch_count_q;
        end
    end

    // Datapath registers. instr_valid follows en_pc only, so it drops after a
    // PC load, when the fetch unit holds the stale-PC word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= 12'd0;
            fetch_count_q <= 16'd0;
            instr_valid_q <= 1'b0;
            flush_q       <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            fetch_count_q <= fetch_count_d;
            instr_valid_q <= en_pc_s;
            flush_q       <= en_new_pc_s;
        end
    end

    assign en_pc       = en_pc_s;
    assign en_new_pc   = en_new_pc_s;
    assign new_pc      = en_new_pc_s ? redirect_pc : 12'd0;
    assign fetch_pc    = fetch_pc_q;
    assign instr_valid = instr_valid_q;
    assign flush       = flush_q;
    assign state       = state_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Self-checking bench for fetch_sequencer. A behavioural model derived from the
// fetch rules predicts every output each cycle. A table of directed vectors
// adds hand-derived constants, and a few sequences cover the wrap, reset and
// single-step corner cases. Randomized traffic runs after these.
// Build with FETCH_SEQ_STEP_EN defined to exercise single-step mode.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

`ifdef FETCH_SEQ_STEP_EN
    localparam bit STEP_MODE = 1'b1;
    logic step_v;
`else
    localparam bit STEP_MODE = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic        halt_req;
    logic        stall;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic        en_pc;
    logic        en_new_pc;
    logic [11:0] new_pc;
    logic [11:0] fetch_pc;
    logic        instr_valid;
    logic        flush;
    logic [2:0]  state;
    logic [15:0] fetch_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: state number, PC, count and the two registered flags.
    int m_state;
    int m_pc;
    int m_cnt;
    bit m_iv;
    bit m_fl;
    // Predictions for the cycle that is currently being applied.
    bit p_en;
    bit p_new;
    int p_next;
    int p_rpc;

    fetch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .halt_req    (halt_req),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
`ifdef FETCH_SEQ_STEP_EN
        .step        (step_v),
`endif
        .en_pc       (en_pc),
        .en_new_pc   (en_new_pc),
        .new_pc      (new_pc),
        .fetch_pc    (fetch_pc),
        .instr_valid (instr_valid),
        .flush       (flush),
        .state       (state),
        .fetch_count (fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        bit          st, hr, sl, rd;
        logic [11:0] rpc;
        bit          en, nw;
        logic [11:0] npc;
        logic [2:0]  s;
        logic [11:0] pc;
        logic [15:0] cnt;
        bit          iv, fl;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input int st, hr, sl, rd, rpc, en, nw, npc, s, pc, cnt, iv, fl);
        vec_t v;
        v.st = st[0]; v.hr = hr[0]; v.sl = sl[0]; v.rd = rd[0];
        v.rpc = rpc[11:0]; v.en = en[0]; v.nw = nw[0]; v.npc = npc[11:0];
        v.s = s[2:0]; v.pc = pc[11:0]; v.cnt = cnt[15:0]; v.iv = iv[0]; v.fl = fl[0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Next mode from the fetch rules. Outside IDLE/HALTED, halt beats everything,
    // the REDIRECT bubble always returns to RUN, redirect beats stall.
    function automatic int model_next(input bit st, hr, sl, rd);
        if (m_state == 0) return st ? 1 : 0;
        if (m_state == 4) return (st && !hr) ? 1 : 4;
        if (hr) return 4;
        if (m_state == 3) return 1;
        if (rd) return 3;
        if (sl) return 2;
        return 1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_pc = 0; m_cnt = 0; m_iv = 1'b0; m_fl = 1'b0;
    endtask

    // Drive one cycle's inputs at the falling edge and check all outputs.
    task automatic apply(input bit st, hr, sl, rd, input logic [11:0] rpc, input bit sp);
        @(negedge clk);
        start = st; halt_req = hr; stall = sl; redirect = rd; redirect_pc = rpc;
`ifdef FETCH_SEQ_STEP_EN
        step_v = sp;
`endif
        #2;
        p_en   = (m_state == 1) && !hr && !rd && !sl && (!STEP_MODE || sp);
        p_new  = ((m_state == 1) || (m_state == 2)) && !hr && rd;
        p_rpc  = int'(rpc);
        p_next = model_next(st, hr, sl, rd);
        chk("en_pc", en_pc, p_en);
        chk("en_new_pc", en_new_pc, p_new);
        chk("new_pc", new_pc, p_new ? p_rpc : 0);
        chk("state", state, m_state);
        chk("fetch_pc", fetch_pc, m_pc);
        chk("fetch_count", fetch_count, m_cnt);
        chk("instr_valid", instr_valid, m_iv);
        chk("flush", flush, m_fl);
    endtask

    // Clock edge: move the model forward with the predictions made in apply.
    task automatic advance();
        @(posedge clk);
        if (p_new) m_pc = p_rpc;
        else if (p_en) m_pc = (m_pc + 1) % 4096;
        if (p_en && m_cnt < 65535) m_cnt = m_cnt + 1;
        m_iv = p_en;
        m_fl = p_new;
        m_state = p_next;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; halt_req = 1'b0; stall = 1'b0; redirect = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int strobes;
        reset = 1'b1; start = 1'b0; halt_req = 1'b0; stall = 1'b0;
        redirect = 1'b0; redirect_pc = 12'd0;
`ifdef FETCH_SEQ_STEP_EN
        step_v = 1'b1;
`endif
        model_reset();
        #3;
        chk("rst_state", state, 0);
        chk("rst_fetch_pc", fetch_pc, 0);
        chk("rst_count", fetch_count, 0);
        chk("rst_iv", instr_valid, 0);
        chk("rst_flush", flush, 0);
        chk("rst_strobes", {en_pc, en_new_pc, new_pc}, 0);
        @(negedge clk);
        reset = 1'b0;

        // start/run 5, stall 3, redirect+stall, bubble, halt+redirect, restart
        tbl[0]  = mk(1,0,0,0,0,     0,0,0,     0,0,0,     0,0);
        tbl[1]  = mk(0,0,0,0,0,     1,0,0,     1,0,0,     0,0);
        tbl[2]  = mk(0,0,0,0,0,     1,0,0,     1,1,1,     1,0);
        tbl[3]  = mk(0,0,0,0,0,     1,0,0,     1,2,2,     1,0);
        tbl[4]  = mk(0,0,0,0,0,     1,0,0,     1,3,3,     1,0);
        tbl[5]  = mk(0,0,0,0,0,     1,0,0,     1,4,4,     1,0);
        tbl[6]  = mk(0,0,1,0,0,     0,0,0,     1,5,5,     1,0);
        tbl[7]  = mk(0,0,1,0,0,     0,0,0,     2,5,5,     0,0);
        tbl[8]  = mk(0,0,1,0,0,     0,0,0,     2,5,5,     0,0);
        tbl[9]  = mk(0,0,0,0,0,     0,0,0,     2,5,5,     0,0);
        tbl[10] = mk(0,0,0,0,0,     1,0,0,     1,5,5,     0,0);
        tbl[11] = mk(0,0,1,1,'h200, 0,1,'h200, 1,6,6,     1,0);
        tbl[12] = mk(0,0,0,0,0,     0,0,0,     3,'h200,6, 0,1);
        tbl[13] = mk(0,0,0,0,0,     1,0,0,     1,'h200,6, 0,0);
        tbl[14] = mk(0,1,0,1,'h3AB, 0,0,0,     1,'h201,7, 1,0);
        tbl[15] = mk(0,0,0,0,0,     0,0,0,     4,'h201,7, 0,0);
        tbl[16] = mk(1,0,0,0,0,     0,0,0,     4,'h201,7, 0,0);
        tbl[17] = mk(0,0,0,0,0,     1,0,0,     1,'h201,7, 0,0);
        tbl[18] = mk(0,0,0,0,0,     1,0,0,     1,'h202,8, 1,0);

        for (int i = 0; i < 19; i++) begin
            apply(tbl[i].st, tbl[i].hr, tbl[i].sl, tbl[i].rd, tbl[i].rpc, 1'b1);
            chk($sformatf("tbl%0d_en", i), en_pc, tbl[i].en);
            chk($sformatf("tbl%0d_new", i), en_new_pc, tbl[i].nw);
            chk($sformatf("tbl%0d_npc", i), new_pc, tbl[i].npc);
            chk($sformatf("tbl%0d_state", i), state, tbl[i].s);
            chk($sformatf("tbl%0d_pc", i), fetch_pc, tbl[i].pc);
            chk($sformatf("tbl%0d_cnt", i), fetch_count, tbl[i].cnt);
            chk($sformatf("tbl%0d_iv", i), instr_valid, tbl[i].iv);
            chk($sformatf("tbl%0d_fl", i), flush, tbl[i].fl);
            advance();
        end

        // PC wrap: redirect to 4095, bubble, one fetch -> PC 0, count 9 -> 10.
        apply(0, 0, 0, 1, 12'hFFF, 1'b1); advance();
        apply(0, 0, 0, 0, 12'h000, 1'b1); advance();
        apply(0, 0, 0, 0, 12'h000, 1'b1);
        chk("wrap_pre_pc", fetch_pc, 'hFFF);
        chk("wrap_pre_en", en_pc, 1);
        advance();
        apply(0, 0, 1, 0, 12'h000, 1'b1);
        chk("wrap_pc", fetch_pc, 0);
        chk("wrap_cnt", fetch_count, 10);
        advance();

        // Reset during the REDIRECT bubble (flush would otherwise be 1).
        apply(0, 0, 0, 1, 12'h123, 1'b1); advance();
        @(negedge clk);
        redirect = 1'b0;
        #1 reset = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_state", state, 0);
        chk("mid_rst_pc", fetch_pc, 0);
        chk("mid_rst_cnt", fetch_count, 0);
        chk("mid_rst_flush", flush, 0);
        chk("mid_rst_iv", instr_valid, 0);
        chk("mid_rst_strobes", {en_pc, en_new_pc, new_pc}, 0);
        @(posedge clk);
        #1;
        chk("rst_hold_state", state, 0);
        chk("rst_hold_strobes", {en_pc, en_new_pc, new_pc}, 0);
        @(negedge clk);
        reset = 1'b0;
        strobes = 0;
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1,
                  12'($urandom), 1'b1);
            if (en_pc || en_new_pc) strobes++;
            advance();
        end
        chk("post_rst_no_strobe", strobes, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            apply(1'($urandom_range(7) == 0), 1'($urandom_range(9) == 0),
                  1'($urandom_range(3) == 0), 1'($urandom_range(5) == 0),
                  12'($urandom), STEP_MODE ? 1'($urandom_range(1)) : 1'b1);
            chk("excl_strobes", en_pc & en_new_pc, 0);
            advance();
        end

`ifdef FETCH_SEQ_STEP_EN
        // Single step: three step pulses in ten RUN cycles -> three fetches.
        do_reset();
        apply(1, 0, 0, 0, 12'h000, 1'b0); advance();
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            apply(0, 0, 0, 0, 12'h000, (i == 1) || (i == 4) || (i == 7));
            if (en_pc) strobes++;
            advance();
        end
        chk("step_count", strobes, 3);
        chk("step_pc", fetch_pc, 3);
`else
        do_reset();
        apply(1, 0, 0, 0, 12'h000, 1'b1); advance();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 12'h000, 1'b1); advance();
        end
        apply(0, 0, 0, 0, 12'h000, 1'b1);
        chk("free_run_pc", fetch_pc, 3);
        advance();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  clock; reset is asynchronous, active-high.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; leave IDLE/HALTED and begin fetching.
- halt_req  in  1  level; stop fetching.
- stall  in  1  level; hold PC, no fetch.
- redirect  in  1  single-cycle; load redirect_pc into the fetch PC.
- redirect_pc  in  12  branch/jump target.
- en_pc  out  1  increment-PC strobe to the fetch unit.
- en_new_pc  out  1  load-PC strobe to the fetch unit.
- new_pc  out  12  PC value to load.
- fetch_pc  out  12  shadow copy of the fetch unit PC.
- instr_valid  out  1  the fetch unit instruction register holds a correct instruction this cycle.
- flush  out  1  one-cycle pulse; discard the instruction in flight.
- state  out  3  FSM state encoding.
- fetch_count  out  16  number of en_pc strobes issued.

Function
REQ-002 The FSM SHALL have states IDLE=0, RUN=1, STALL=2, REDIRECT=3, HALTED=4; encodings 5-7 SHALL return to IDLE on the next clock.
REQ-003 Input priority SHALL be halt_req > redirect > stall in every state except IDLE.
REQ-004 IDLE: all strobes are 0; start SHALL transition the FSM to RUN.
REQ-005 RUN: en_pc SHALL be 1 combinationally when halt_req=0, redirect=0 and stall=0.
REQ-006 RUN: stall=1 (with no higher-priority input) SHALL transition to STALL, with en_pc=0 in that cycle.
REQ-007 STALL: en_pc SHALL be 0; stall=0 SHALL transition to RUN; fetching resumes in the following cycle.
REQ-008 In RUN or STALL, redirect=1 SHALL drive en_new_pc=1 and new_pc=redirect_pc in the same cycle, then transition to REDIRECT.
REQ-009 REDIRECT SHALL last exactly one cycle with en_pc=0 (bubble), then transition to RUN unconditionally unless halt_req=1.
REQ-010 flush SHALL be a registered signal equal to 1 in the cycle after en_new_pc=1, and 0 otherwise.
REQ-011 halt_req in RUN, STALL or REDIRECT SHALL transition to HALTED with all strobes 0; start in HALTED SHALL transition to RUN, fetching from the unchanged fetch_pc.
REQ-012 new_pc SHALL equal redirect_pc when en_new_pc=1, and 0 otherwise.
REQ-013 fetch_pc SHALL load redirect_pc on en_new_pc, else increment by 1 on en_pc, wrapping from 4095 to 0.
REQ-014 instr_valid SHALL be a registered copy of en_pc (1 the cycle after each en_pc); it SHALL be 0 after en_new_pc, because the fetch unit latches the stale-PC word on load.
REQ-015 fetch_count SHALL increment on each en_pc and saturate at 0xFFFF.
REQ-016 en_pc and en_new_pc SHALL never both be 1 in the same cycle.

Reset
REQ-017 Asserting reset SHALL immediately force state=IDLE, fetch_pc=0, fetch_count=0, instr_valid=0 and flush=0.
REQ-018 While reset is asserted, en_pc, en_new_pc and new_pc SHALL be 0.
REQ-019 Reset asserted mid-redirect or mid-stall SHALL discard the pending operation; no strobe SHALL follow reset release until start is asserted.

Configuration
REQ-020 The macro FETCH_SEQ_STEP_EN SHALL control single-step mode.
- Defined: add input port step (1 bit); in RUN, en_pc SHALL be 1 only in cycles where step=1 (subject to REQ-005 gating); the FSM otherwise holds RUN with en_pc=0.
- Undefined: no step port; RUN fetches every eligible cycle.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Reset, start=1 for 1 cycle, run 5 cycles -> en_pc high for 5 cycles, fetch_pc=5, fetch_count=5, instr_valid high from cycle 2.
- fetch_pc=4095, one en_pc -> fetch_pc=0, fetch_count increments.
- In RUN, redirect=1 with redirect_pc=0x200 and stall=1 in the same cycle -> en_new_pc=1, new_pc=0x200; flush=1 next cycle; REDIRECT bubble; en_pc resumes; fetch_pc=0x201 after the first fetch.
- stall held 3 cycles -> en_pc=0 for 3 cycles plus 1 STALL-exit cycle, fetch_pc unchanged, instr_valid=0.
- halt_req together with redirect in RUN -> HALTED, en_new_pc=0, fetch_pc unchanged; start -> RUN continues from the same PC.
- Reset pulsed in the REDIRECT state -> state=0, fetch_pc=0, flush=0, no strobes until start; with FETCH_SEQ_STEP_EN defined, 3 step pulses -> exactly 3 en_pc.
